// File: rtl/cons_cell_store.sv
// Cons-cell memory: car/cdr fetch, set-car/set-cdr, bump-pointer cons.
// Ports: clk, rst(n), req/opcode/addr/car_in/cdr_in in; data_out/is_ready/done/error/full/alloc_count out.
module cons_cell_store #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 8,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [2:0]            opcode,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] car_in,
  input  logic [DATA_WIDTH-1:0] cdr_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  is_ready,
  output logic                  done,
  output logic                  error,
  output logic                  full,
  output logic [ADDR_WIDTH-1:0] alloc_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]         cnt;
  logic [2:0]            op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] car_q;
  logic [DATA_WIDTH-1:0] cdr_q;
  logic [ADDR_WIDTH-1:0] free_ptr;
  logic                  full_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  err_q;

  logic [DATA_WIDTH-1:0] car_mem [DEPTH];
  logic [DATA_WIDTH-1:0] cdr_mem [DEPTH];

  logic                  accept;
  logic                  exec;
  logic                  valid;
  logic                  is_nil;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  res_err;
  logic                  wr_car;
  logic                  wr_cdr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  do_alloc;

  logic op_nop, op_gcar, op_gcdr, op_scar, op_scdr, op_cons;

  assign accept = req && (state != WAIT);
  assign exec   = (state == WAIT) && (cnt == '0);

  assign is_nil = (addr_q == '0);
  // Once the free pointer has wrapped, every non-nil cell is allocated.
  assign valid  = !is_nil && (full_q || (addr_q < free_ptr));

  assign op_nop  = (op_q == 3'b000);
  assign op_gcar = (op_q == 3'b001);
  assign op_gcdr = (op_q == 3'b010);
  assign op_scar = (op_q == 3'b011);
  assign op_scdr = (op_q == 3'b100);
  assign op_cons = (op_q == 3'b101);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (req) state_nxt = WAIT;
      WAIT: if (cnt == '0) state_nxt = DONE;
      DONE: state_nxt = req ? WAIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    res_data = '0;
    res_err  = 1'b0;
    wr_car   = 1'b0;
    wr_cdr   = 1'b0;
    wr_addr  = addr_q;
    do_alloc = 1'b0;
    unique case (1'b1)
      op_nop: begin
        res_err = 1'b0;
      end
      op_gcar: begin
        if (valid) res_data = car_mem[addr_q];
        res_err = !valid && !is_nil;
      end
      op_gcdr: begin
        if (valid) res_data = cdr_mem[addr_q];
        res_err = !valid && !is_nil;
      end
      op_scar: begin
        wr_car   = valid;
        res_data = valid ? DATA_WIDTH'(addr_q) : '0;
        res_err  = !valid;
      end
      op_scdr: begin
        wr_cdr   = valid;
        res_data = valid ? DATA_WIDTH'(addr_q) : '0;
        res_err  = !valid;
      end
      op_cons: begin
        wr_addr = free_ptr;
        if (!full_q) begin
          wr_car   = 1'b1;
          wr_cdr   = 1'b1;
          do_alloc = 1'b1;
          res_data = DATA_WIDTH'(free_ptr);
        end
        res_err = full_q;
      end
      default: begin
        res_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= '0;
      addr_q   <= '0;
      car_q    <= '0;
      cdr_q    <= '0;
      free_ptr <= ADDR_WIDTH'(1);
      full_q   <= 1'b0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q   <= opcode;
        addr_q <= addr;
        car_q  <= car_in;
        cdr_q  <= cdr_in;
        cnt    <= CNT_LOAD;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (exec) begin
        data_q <= res_data;
        err_q  <= res_err;
        if (do_alloc) begin
          free_ptr <= free_ptr + 1'b1;
          if (free_ptr == '1) full_q <= 1'b1;
        end
      end
    end
  end

  // Storage is deliberately not reset; reset drops state to IDLE
  // asynchronously, so an in-flight op can never reach its write.
  always_ff @(posedge clk) begin
    if (exec && wr_car) car_mem[wr_addr] <= car_q;
    if (exec && wr_cdr) cdr_mem[wr_addr] <= (op_cons || op_scdr) ? cdr_q : cdr_mem[wr_addr];
  end

  assign data_out    = data_q;
  assign error       = err_q;
  assign full        = full_q;
  assign done        = (state == DONE);
  assign is_ready    = (state != WAIT);
  assign alloc_count = full_q ? '1 : (free_ptr - ADDR_WIDTH'(1));

endmodule

// File: tb/tb_cons_cell_store.sv
// Directed bench for cons_cell_store (ADDR_WIDTH=3, ACCESS_CYCLES=2).
// Hand-computed expectations, one checking task, one summary line.
module tb_cons_cell_store;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int AC = 2;

  localparam logic [2:0] NOP  = 3'b000;
  localparam logic [2:0] GCAR = 3'b001;
  localparam logic [2:0] GCDR = 3'b010;
  localparam logic [2:0] SCAR = 3'b011;
  localparam logic [2:0] SCDR = 3'b100;
  localparam logic [2:0] CONS = 3'b101;
  localparam logic [2:0] RSV  = 3'b110;

  logic          clk;
  logic          rst;
  logic          req;
  logic [2:0]    opcode;
  logic [AW-1:0] addr;
  logic [DW-1:0] car_in;
  logic [DW-1:0] cdr_in;
  logic [DW-1:0] data_out;
  logic          is_ready;
  logic          done;
  logic          error;
  logic          full;
  logic [AW-1:0] alloc_count;

  int total = 0;
  int bad   = 0;

  cons_cell_store #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .ACCESS_CYCLES(AC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .opcode(opcode),
    .addr(addr),
    .car_in(car_in),
    .cdr_in(cdr_in),
    .data_out(data_out),
    .is_ready(is_ready),
    .done(done),
    .error(error),
    .full(full),
    .alloc_count(alloc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op and wait for done; returns negedges from accept to done.
  task automatic run_op(input logic [2:0] op, input logic [AW-1:0] a,
                        input logic [DW-1:0] ca, input logic [DW-1:0] cd,
                        output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!is_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    req = 1'b1;
    opcode = op;
    addr = a;
    car_in = ca;
    cdr_in = cd;
    @(posedge clk);
    #1 req = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 20);
    if (!done) chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic op_chk(input string tag, input logic [2:0] op,
                        input logic [AW-1:0] a, input logic [DW-1:0] ca,
                        input logic [DW-1:0] cd, input logic [DW-1:0] exp_d,
                        input logic exp_e);
    int lat;
    run_op(op, a, ca, cd, lat);
    chk({tag, "_data"}, 32'(data_out), 32'(exp_d));
    chk({tag, "_err"}, 32'(error), 32'(exp_e));
  endtask

  initial begin
    int lat;
    int last;
    int nd;
    logic [DW-1:0] exp_d;

    rst = 1'b0;
    req = 1'b0;
    opcode = NOP;
    addr = '0;
    car_in = '0;
    cdr_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(is_ready), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_alloc", 32'(alloc_count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_err", 32'(error), 32'd0);
    rst = 1'b1;

    run_op(CONS, '0, 16'h0011, 16'h0000, lat);
    chk("cons1_lat", 32'(lat), 32'(AC + 1));
    chk("cons1_data", 32'(data_out), 32'd1);
    chk("cons1_err", 32'(error), 32'd0);
    chk("cons1_alloc", 32'(alloc_count), 32'd1);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);

    op_chk("cons2", CONS, '0, 16'h00AA, 16'h0001, 16'd2, 1'b0);
    op_chk("gcar2", GCAR, 3'd2, '0, '0, 16'h00AA, 1'b0);
    op_chk("gcdr2", GCDR, 3'd2, '0, '0, 16'h0001, 1'b0);
    op_chk("gcar_nil", GCAR, 3'd0, '0, '0, 16'h0000, 1'b0);
    op_chk("scdr1", SCDR, 3'd1, '0, 16'h0002, 16'd1, 1'b0);
    op_chk("gcdr1", GCDR, 3'd1, '0, '0, 16'h0002, 1'b0);
    op_chk("gcar1", GCAR, 3'd1, '0, '0, 16'h0011, 1'b0);
    op_chk("scar_nil", SCAR, 3'd0, 16'h0055, '0, 16'h0000, 1'b1);
    op_chk("gcar_unal", GCAR, 3'd5, '0, '0, 16'h0000, 1'b1);
    op_chk("scar_unal", SCAR, 3'd4, 16'h0066, '0, 16'h0000, 1'b1);
    op_chk("scar2", SCAR, 3'd2, 16'h00BB, '0, 16'd2, 1'b0);
    op_chk("gcar2b", GCAR, 3'd2, '0, '0, 16'h00BB, 1'b0);
    op_chk("gcdr2b", GCDR, 3'd2, '0, '0, 16'h0001, 1'b0);
    op_chk("nop", NOP, 3'd1, '0, '0, 16'h0000, 1'b0);
    op_chk("rsv", RSV, 3'd1, '0, '0, 16'h0000, 1'b1);
    chk("alloc_2", 32'(alloc_count), 32'd2);

    for (int i = 3; i <= 7; i++) begin
      op_chk($sformatf("cons%0d", i), CONS, '0, DW'(16'h0100 + i),
             DW'(i), DW'(i), 1'b0);
      chk($sformatf("full%0d", i), 32'(full), (i == 7) ? 32'd1 : 32'd0);
      chk($sformatf("alloc%0d", i), 32'(alloc_count), 32'(i));
    end
    op_chk("gcar5_full", GCAR, 3'd5, '0, '0, 16'h0105, 1'b0);
    op_chk("gcdr7_full", GCDR, 3'd7, '0, '0, 16'h0007, 1'b0);
    op_chk("cons8", CONS, '0, 16'h0999, 16'h0999, 16'h0000, 1'b1);
    chk("cons8_full", 32'(full), 32'd1);
    chk("cons8_alloc", 32'(alloc_count), 32'd7);

    // Back-to-back: req held high, op switched on each done cycle.
    @(negedge clk);
    req = 1'b1;
    opcode = GCAR;
    addr = 3'd2;
    nd = 0;
    last = 0;
    for (int c = 1; c <= 40 && nd < 4; c++) begin
      @(negedge clk);
      if (done) begin
        exp_d = (nd % 2 == 0) ? 16'h00BB : 16'h0001;
        chk($sformatf("b2b%0d_data", nd), 32'(data_out), 32'(exp_d));
        if (nd > 0) chk($sformatf("b2b%0d_per", nd), 32'(c - last), 32'(AC + 1));
        last = c;
        nd++;
        opcode = (nd % 2 == 0) ? GCAR : GCDR;
        if (nd == 4) req = 1'b0;
      end
    end
    chk("b2b_count", 32'(nd), 32'd4);

    // req pulse during WAIT must be ignored.
    @(negedge clk);
    @(negedge clk);
    req = 1'b1;
    opcode = GCAR;
    addr = 3'd1;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    chk("wait_ready", 32'(is_ready), 32'd0);
    req = 1'b1;
    opcode = CONS;
    @(posedge clk);
    #1 req = 1'b0;
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("ign_dones", 32'(nd), 32'd1);
    chk("ign_data", 32'(data_out), 32'h0011);
    chk("ign_err", 32'(error), 32'd0);

    // Async reset mid-WAIT of a SET_CAR.
    @(negedge clk);
    req = 1'b1;
    opcode = SCAR;
    addr = 3'd1;
    car_in = 16'h0099;
    @(posedge clk);
    #1 req = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_ready", 32'(is_ready), 32'd1);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_alloc", 32'(alloc_count), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_data", 32'(data_out), 32'd0);
    chk("arst_err", 32'(error), 32'd0);
    repeat (3) @(negedge clk);
    chk("arst_hold_done", 32'(done), 32'd0);
    rst = 1'b1;
    chk("post_alloc", 32'(alloc_count), 32'd0);
    op_chk("post_gcar1", GCAR, 3'd1, '0, '0, 16'h0000, 1'b1);
    op_chk("post_cons", CONS, '0, 16'h0077, 16'h0088, 16'd1, 1'b0);
    chk("post_alloc1", 32'(alloc_count), 32'd1);
    op_chk("post_gcar", GCAR, 3'd1, '0, '0, 16'h0077, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
